bcd_converter_seq: RTL and testbench
====================================

# bcd_converter_seq

Sequential, parametrised binary-to-BCD converter for the FPGA output path. It takes a WIDTH-bit word, signed or unsigned per request, and performs one double-dabble step per clock under a start/busy/done handshake. It drives packed BCD digits, a sign flag, an overflow flag and a significant-digit count to the seven-segment display logic. It replaces the single-cycle combinational converter, which is too deep to close timing at wider words.

## Interface
- WIDTH, 32, bit width of the binary input (≥ 4)
- DIGITS, 10, number of BCD digits produced (≥ 1); 10 covers the full 32-bit unsigned range
- CNT_W, $clog2(WIDTH+1), width of the internal step counter (derived; do not override)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only when busy = 0
- signed_mode  in  1  1 = treat value as two's complement; sampled with start
- value  in  WIDTH  binary word to convert; sampled with start
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; results valid and updated this cycle
- decimal  out  4*DIGITS  packed BCD; digit k at bits [4k+3:4k]; digit 0 is least significant
- negative  out  1  result sign (1 only if signed_mode and value[WIDTH-1])
- overflow  out  1  magnitude does not fit in DIGITS digits
- digits_used  out  $clog2(DIGITS+1)  index of the most significant non-zero digit + 1; minimum 1

## Operation
- States: IDLE, CONVERT, DONE.
- IDLE or DONE with start = 1:
  - Load magnitude: if signed_mode and value[WIDTH-1], use (~value + 1) and set neg_pending; otherwise use value.
  - Clear the BCD accumulator and the overflow accumulator.
  - Set step counter = WIDTH and go to CONVERT.
- CONVERT, each cycle:
  - For every digit ≥ 5, add 3 (all digits adjusted in parallel from the pre-shift value).
  - Shift {bcd, magnitude} left by 1.
  - If the bit shifted out of the top of bcd is 1, set the overflow accumulator.
  - Decrement the counter.
  - When the counter reaches 1 on this cycle, go to DONE.
- Entering DONE:
  - Register decimal = final bcd, negative = neg_pending, overflow = accumulator, and digits_used.
  - digits_used = 1 for a zero result. On overflow it is still computed from the truncated bcd.
- DONE: done = 1 for exactly one cycle. Without start, return to IDLE. With start, load a new request as in IDLE (back-to-back).
- start while in CONVERT is ignored, not queued.
- Most-negative input (signed_mode, value = 1 followed by WIDTH−1 zeros): the magnitude is 2^(WIDTH−1) and is representable, so no special case is needed.
- decimal, negative, overflow and digits_used hold their values from DONE until the next DONE. They do not change during CONVERT.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, decimal = 0, negative = 0, overflow = 0, digits_used = 1; internal registers cleared.
- Reset during CONVERT aborts the conversion: no done pulse, outputs return to their reset values the following cycle, and the aborted request is discarded.
- start sampled at edge t0 → busy = 1 in cycles t0+1 … t0+WIDTH → done = 1 with new outputs in cycle t0+WIDTH+1.
- Latency: WIDTH+1 cycles from start to done. Back-to-back throughput: one result per WIDTH+1 cycles.
- busy = 0 in IDLE and DONE; done and busy are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=32, DIGITS=10, signed_mode=1, value=0xFFFF_FF85 → done at start+33; decimal=0x00_0000_0123, negative=1, overflow=0, digits_used=3.
- signed_mode=0, value=0xFFFF_FFFF → decimal=0x42_9496_7295, negative=0, overflow=0, digits_used=10. Then signed_mode=1 with the same value → decimal=1, negative=1, digits_used=1.
- DIGITS=8, signed_mode=0, value=100_000_000 → overflow=1, decimal=0x0000_0000, digits_used=1. Then value=99_999_999 → overflow=0, decimal=0x9999_9999, digits_used=8.
- value=0 → decimal=0, negative=0, digits_used=1. Then signed_mode=1, value=0x8000_0000 → decimal=0x21_4748_3648, negative=1.
- start pulses in cycles 5 and 10 after the first start → both ignored, single done at start+33. start asserted in the done cycle → second done at exactly done+33.
- reset asserted at cycle 15 of a conversion → no done pulse, all outputs at reset values next cycle. A new start after reset converts correctly.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double dabble, one step per clock).
// Accepts signed or unsigned words. Produces packed BCD digits, a sign flag,
// an overflow flag and a significant-digit count. Outputs are registered
// and hold their values between done pulses.
module bcd_converter_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic [WIDTH-1:0]             value,
  output logic                         busy,
  output logic                         done,
  output logic [4*DIGITS-1:0]          decimal,
  output logic                         negative,
  output logic                         overflow,
  output logic [$clog2(DIGITS+1)-1:0]  digits_used
);

  localparam int DU_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    mag_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic                ovf_reg;
  logic                neg_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_next;
  logic [WIDTH-1:0]    mag_next;
  logic                carry_out;
  logic [DIGITS-1:0]   digit_nz;
  logic [DU_W-1:0]     du_next;
  logic [WIDTH-1:0]    mag_load;
  logic                neg_load;

  // The most negative input negates to 2^(WIDTH-1), which still fits in WIDTH
  // unsigned bits, so it needs no special case.
  assign neg_load = signed_mode & value[WIDTH-1];
  assign mag_load = neg_load ? ((~value) + WIDTH'(1)) : value;

  // Add-3 correction for each digit. All digits are corrected in parallel
  // from the pre-shift accumulator value.
  // The post-shift digits are also flagged non-zero here, for the
  // significant-digit count.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
    assign digit_nz[gi] = |bcd_next[4*gi +: 4];
  end

  // Shift {bcd, magnitude} left by one. The bit leaving the top digit is lost
  // precision, so it is reported as overflow.
  assign bcd_next  = {bcd_adj[4*DIGITS-2:0], mag_reg[WIDTH-1]};
  assign carry_out = bcd_adj[4*DIGITS-1];
  assign mag_next  = {mag_reg[WIDTH-2:0], 1'b0};

  // The count is the position of the highest non-zero digit plus one.
  // It is 1 for a zero result.
  always_comb begin
    du_next = DU_W'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_nz[k]) du_next = DU_W'(k + 1);
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      mag_reg     <= '0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      neg_reg     <= 1'b0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      decimal     <= '0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      digits_used <= DU_W'(1);
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mag_reg   <= mag_load;
            neg_reg   <= neg_load;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= CNT_W'(WIDTH);
            busy      <= 1'b1;
            state_reg <= CONVERT;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        CONVERT: begin
          bcd_reg <= bcd_next;
          mag_reg <= mag_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (carry_out) ovf_reg <= 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            decimal     <= bcd_next;
            negative    <= neg_reg;
            overflow    <= ovf_reg | carry_out;
            digits_used <= du_next;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Testbench for bcd_converter_seq. It drives two instances with the same
// inputs: a 10-digit one and an 8-digit one.
// The stimulus pushes expected results into per-instance queues. A monitor
// pops them and compares on every done pulse. Expected values come from a
// decimal-arithmetic reference model.
module tb_bcd_converter_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] value;

  logic        busy_a, done_a, neg_a, ovf_a;
  logic [39:0] dec_a;
  logic [3:0]  du_a;
  logic        busy_b, done_b, neg_b, ovf_b;
  logic [31:0] dec_b;
  logic [3:0]  du_b;

  bcd_converter_seq #(.WIDTH(32), .DIGITS(10)) dut_a (
    .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
    .value(value), .busy(busy_a), .done(done_a), .decimal(dec_a),
    .negative(neg_a), .overflow(ovf_a), .digits_used(du_a)
  );

  bcd_converter_seq #(.WIDTH(32), .DIGITS(8)) dut_b (
    .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
    .value(value), .busy(busy_b), .done(done_b), .decimal(dec_b),
    .negative(neg_b), .overflow(ovf_b), .digits_used(du_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] dec;
    bit          neg;
    bit          ovf;
    int          du;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: the magnitude as a plain integer, reduced modulo 10^d and
  // split into decimal digits.
  function automatic exp_t model(bit sgn, logic [31:0] v, int d, int ecyc);
    exp_t e;
    longint unsigned mag, lim, rem, dg;
    e.neg = sgn && v[31];
    mag = e.neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    lim = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    e.ovf = (mag >= lim);
    rem   = mag % lim;
    e.dec = '0;
    e.du  = 1;
    for (int k = 0; k < d; k++) begin
      dg = rem % 10;
      e.dec[4*k +: 4] = dg[3:0];
      if (dg != 0) e.du = k + 1;
      rem = rem / 10;
    end
    e.cyc = ecyc;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_item(string tag, exp_t e, logic [39:0] dec, bit neg,
                            bit ovf, int du, bit busy);
    $display("[cyc %0d] %s done: decimal=%h negative=%0d overflow=%0d digits_used=%0d",
             cyc, tag, dec, neg, ovf, du);
    chk({tag, ".decimal"},     dec,  e.dec);
    chk({tag, ".negative"},    neg,  e.neg);
    chk({tag, ".overflow"},    ovf,  e.ovf);
    chk({tag, ".digits_used"}, du,   e.du);
    chk({tag, ".done_cycle"},  cyc,  e.cyc);
    chk({tag, ".busy_with_done"}, busy, 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (done_a === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a.unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        check_item("a", qa.pop_front(), dec_a, neg_a, ovf_a, int'(du_a), busy_a);
      end
    end
    if (done_b === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b.unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        check_item("b", qb.pop_front(), {8'd0, dec_b}, neg_b, ovf_b, int'(du_b), busy_b);
      end
    end
  end

  // Call at posedge+1. Start is held for one cycle and done is expected 33
  // cycles after the cycle in which start is visible.
  task automatic send(bit sgn, logic [31:0] v);
    signed_mode = sgn;
    value       = v;
    start       = 1'b1;
    qa.push_back(model(sgn, v, 10, cyc + 33));
    qb.push_back(model(sgn, v, 8, cyc + 33));
    @(posedge clock); #1;
    start       = 1'b0;
    signed_mode = 1'($urandom);
    value       = $urandom;
  endtask

  // Returns at posedge+1 of the done cycle, or flags a timeout.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clock); #1;
      if (done_a === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_done: got no done within 60 cycles expected done");
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".a.decimal"}, dec_a, 0);
    chk({tag, ".a.negative"}, neg_a, 0);
    chk({tag, ".a.overflow"}, ovf_a, 0);
    chk({tag, ".a.digits_used"}, du_a, 1);
    chk({tag, ".a.busy"}, busy_a, 0);
    chk({tag, ".a.done"}, done_a, 0);
    chk({tag, ".b.decimal"}, dec_b, 0);
    chk({tag, ".b.digits_used"}, du_b, 1);
    chk({tag, ".b.busy"}, busy_b, 0);
  endtask

  initial begin
    logic [31:0] v;
    bit          s;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; value = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk_reset("reset_state");

    // Directed cases
    send(1'b1, 32'hFFFF_FF85); wait_done();
    @(posedge clock); #1;
    send(1'b0, 32'hFFFF_FFFF); wait_done();
    send(1'b1, 32'hFFFF_FFFF); wait_done();
    send(1'b0, 32'd100_000_000); wait_done();
    send(1'b0, 32'd99_999_999); wait_done();
    send(1'b0, 32'd0); wait_done();
    send(1'b1, 32'h8000_0000); wait_done();
    @(posedge clock); #1;

    // Starts during CONVERT are ignored.
    send(1'b0, 32'd12_345_678);
    repeat (4) @(posedge clock);
    #1 start = 1'b1; value = 32'd777;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 start = 1'b1; value = 32'd888;
    @(posedge clock); #1 start = 1'b0;
    wait_done();
    // A start in the done cycle runs back-to-back.
    send(1'b0, 32'd87_654_321); wait_done();
    @(posedge clock); #1;

    // Reset in cycle 15 of a conversion aborts it.
    send(1'b0, 32'd55_555);
    repeat (14) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    qa.delete(); qb.delete();
    chk_reset("abort");
    repeat (40) @(posedge clock);
    #1;
    send(1'b0, 32'd2024); wait_done();

    // Randomized transactions, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 999);
        1: v = $urandom_range(99_999_990, 100_000_010);
        default: v = $urandom;
      endcase
      s = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
      send(s, v);
      wait_done();
    end

    repeat (3) @(posedge clock);
    #1;
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
